pulse_delay_meter: RTL and testbench

// Measures the delay, in clk_pdm cycles, between a start pulse and a returned stop pulse.
// It is the receive-side counterpart of the delayed-start pulse generator.

---
 rtl/pdm_pkg.sv | 21 ++
 rtl/pdm_edge_sync.sv | 38 +++
 rtl/pulse_delay_meter.sv | 106 ++++++++++
 tb/tb_pulse_delay_meter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// ----------------------------------------------------------------------------
// Module   : pdm_pkg
// Purpose  : Shared state type and default sizing for the pulse delay meter.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pdm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } pdm_state_t;

   localparam int          c_cnt_w_dflt   = 35;
   localparam int unsigned c_timeout_dflt = 200000000;

endpackage

`default_nettype wire

// File: rtl/pdm_edge_sync.sv
// ----------------------------------------------------------------------------
// Module   : pdm_edge_sync
// Purpose  : Multi-stage synchronizer followed by a one-cycle rising-edge detector.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pdm_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_pdm,
   input  logic rst_n,
   input  logic async_in,
   output logic edge_det
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [SYNC_STAGES:0]   r_prime;

   // r_prime fills with ones after reset so a level already high at release never looks like an edge
   always_ff @(posedge clk_pdm or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_prev  <= 1'b0;
         r_prime <= '0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], async_in};
         r_prev  <= r_sync[SYNC_STAGES-1];
         r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign edge_det = r_sync[SYNC_STAGES-1] & ~r_prev & r_prime[SYNC_STAGES];

endmodule

`default_nettype wire

// File: rtl/pulse_delay_meter.sv
// ----------------------------------------------------------------------------
// Module   : pulse_delay_meter
// Purpose  : Counts clk_pdm cycles from a start edge to a stop edge, with timeout.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pulse_delay_meter
   import pdm_pkg::*;
#(
   parameter int          CNT_W       = c_cnt_w_dflt,
   parameter int unsigned TIMEOUT     = c_timeout_dflt,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk_pdm,
   input  logic             rst_n,
   input  logic             start_in,
   input  logic             stop_in,
   output logic [CNT_W-1:0] meas,
   output logic             meas_valid,
   output logic             timeout,
   output logic             busy
);

   localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

   logic             w_start_det;
   logic             w_stop_det;
   pdm_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_meas;
   logic             r_meas_valid;
   logic             r_timeout;
   logic             r_busy;

   // Identical paths on both inputs keep the measured interval unbiased
   pdm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
      .clk_pdm  (clk_pdm),
      .rst_n    (rst_n),
      .async_in (start_in),
      .edge_det (w_start_det)
   );

   pdm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
      .clk_pdm  (clk_pdm),
      .rst_n    (rst_n),
      .async_in (stop_in),
      .edge_det (w_stop_det)
   );

   always_ff @(posedge clk_pdm or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_meas       <= '0;
         r_meas_valid <= 1'b0;
         r_timeout    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         r_timeout    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_det) begin
                  r_state <= ARMED;
                  r_cnt   <= CNT_W'(1);
                  r_busy  <= 1'b1;
               end
            end
            ARMED: begin
               // Stop is checked first so a stop on the last counted cycle still yields a result
               if (w_stop_det) begin
                  r_state      <= DONE;
                  r_meas       <= r_cnt;
                  r_meas_valid <= 1'b1;
                  r_busy       <= 1'b0;
               end else if (r_cnt == c_timeout) begin
                  r_state   <= IDLE;
                  r_cnt     <= '0;
                  r_timeout <= 1'b1;
                  r_busy    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign meas       = r_meas;
   assign meas_valid = r_meas_valid;
   assign timeout    = r_timeout;
   assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pulse_delay_meter.sv
// ----------------------------------------------------------------------------
// Module   : tb_pulse_delay_meter
// Purpose  : Self-checking bench for pulse_delay_meter (TIMEOUT=100, SYNC_STAGES=2).
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pulse_delay_meter;

   localparam int CW = 35;
   localparam int TO = 100;
   localparam int SS = 2;

   logic          clk_pdm = 1'b0;
   logic          rst_n   = 1'b0;
   logic          start_in = 1'b0;
   logic          stop_in  = 1'b0;
   logic [CW-1:0] meas;
   logic          meas_valid;
   logic          timeout;
   logic          busy;

   int total = 0;
   int bad   = 0;

   // Per-trial observations
   int            n_valid, n_to, n_both, n_busy, valid_at, to_at;
   logic          busy_after;
   logic [CW-1:0] valid_meas;
   logic [CW-1:0] exp_meas = '0;

   pulse_delay_meter #(.CNT_W(CW), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
      .clk_pdm    (clk_pdm),
      .rst_n      (rst_n),
      .start_in   (start_in),
      .stop_in    (stop_in),
      .meas       (meas),
      .meas_valid (meas_valid),
      .timeout    (timeout),
      .busy       (busy)
   );

   always #5 clk_pdm = ~clk_pdm;

   // Drives 2-cycle-wide pulses at given cycle indices (negative = absent) and records outputs
   task automatic run_trial(input int st0, input int st1, input int sp0, input int ncyc);
      n_valid = 0; n_to = 0; n_both = 0; n_busy = 0;
      valid_at = -1; to_at = -1; busy_after = 1'bx; valid_meas = '0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk_pdm);
         if (meas_valid === 1'b1) begin
            n_valid++;
            valid_meas = meas;
            if (valid_at < 0) valid_at = c;
         end
         if (timeout === 1'b1) begin
            n_to++;
            if (to_at < 0) to_at = c;
         end
         if (meas_valid === 1'b1 && timeout === 1'b1) n_both++;
         if (busy === 1'b1) n_busy++;
         if (valid_at >= 0 && c == valid_at + 1) busy_after = busy;
         start_in = (st0 >= 0 && c >= st0 && c < st0 + 2) || (st1 >= 0 && c >= st1 && c < st1 + 2);
         stop_in  = (sp0 >= 0 && c >= sp0 && c < sp0 + 2);
      end
      start_in = 1'b0;
      stop_in  = 1'b0;
   endtask

   // Reference: stop rising d cycles after start measures d if 1<=d<=TO, otherwise a timeout
   function automatic bit ref_valid(input int d);
      return (d >= 1 && d <= TO);
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk_pdm);
      total++; if (meas !== '0) begin bad++; $display("FAIL rst_meas got=%0d want=0", meas); end
      total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", meas_valid); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      rst_n = 1'b1;
      repeat (10) @(negedge clk_pdm);
      run_trial(0, -1, -1, 20);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_armed_busy got=%b want=1", busy); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b want=0", busy); end
      total++; if ({meas_valid, timeout} !== 2'b00) begin bad++; $display("FAIL rst_async_flags got=%b want=00", {meas_valid, timeout}); end
      exp_meas = '0;
      // Both inputs held high across reset release must not register as edges
      start_in = 1'b1;
      stop_in  = 1'b1;
      @(negedge clk_pdm);
      rst_n = 1'b1;
      n_busy = 0; n_valid = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk_pdm);
         if (busy === 1'b1) n_busy++;
         if (meas_valid === 1'b1) n_valid++;
      end
      total++; if (n_busy !== 0) begin bad++; $display("FAIL held_high_busy got=%0d want=0", n_busy); end
      total++; if (n_valid !== 0) begin bad++; $display("FAIL held_high_valid got=%0d want=0", n_valid); end
      start_in = 1'b0;
      stop_in  = 1'b0;
      repeat (5) @(negedge clk_pdm);
      run_trial(-1, -1, 3, 15);
      total++; if (n_valid !== 0) begin bad++; $display("FAIL stop_alone_valid got=%0d want=0", n_valid); end
      total++; if (n_busy !== 0) begin bad++; $display("FAIL stop_alone_busy got=%0d want=0", n_busy); end
   endtask

   task automatic test_basic();
      run_trial(0, -1, 37, 50);
      exp_meas = CW'(37);
      total++; if (n_valid !== 1) begin bad++; $display("FAIL basic_nvalid got=%0d want=1", n_valid); end
      total++; if (valid_meas !== exp_meas) begin bad++; $display("FAIL basic_meas got=%0d want=%0d", valid_meas, exp_meas); end
      total++; if (valid_at !== 37 + SS + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", valid_at, 37 + SS + 1); end
      total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy_after); end
      total++; if (n_to !== 0) begin bad++; $display("FAIL basic_timeout got=%0d want=0", n_to); end
   endtask

   task automatic test_minimum();
      run_trial(0, -1, 1, 15);
      exp_meas = CW'(1);
      total++; if (n_valid !== 1 || valid_meas !== exp_meas) begin bad++; $display("FAIL min_meas got=%0d/%0d want=1/%0d", n_valid, valid_meas, exp_meas); end
      run_trial(0, -1, 0, TO + 10);
      total++; if (n_valid !== 0) begin bad++; $display("FAIL together_valid got=%0d want=0", n_valid); end
      total++; if (n_to !== 1) begin bad++; $display("FAIL together_timeout got=%0d want=1", n_to); end
      total++; if (n_busy !== TO) begin bad++; $display("FAIL together_busy_cycles got=%0d want=%0d", n_busy, TO); end
   endtask

   task automatic test_timeout();
      run_trial(0, -1, -1, TO + 10);
      total++; if (n_to !== 1) begin bad++; $display("FAIL to_count got=%0d want=1", n_to); end
      total++; if (to_at !== TO + SS + 1) begin bad++; $display("FAIL to_latency got=%0d want=%0d", to_at, TO + SS + 1); end
      total++; if (n_valid !== 0) begin bad++; $display("FAIL to_valid got=%0d want=0", n_valid); end
      total++; if (meas !== exp_meas) begin bad++; $display("FAIL to_meas_held got=%0d want=%0d", meas, exp_meas); end
      run_trial(0, -1, TO, TO + 10);
      exp_meas = CW'(TO);
      total++; if (n_valid !== 1 || valid_meas !== exp_meas) begin bad++; $display("FAIL edge_stop_meas got=%0d/%0d want=1/%0d", n_valid, valid_meas, exp_meas); end
      total++; if (n_to !== 0) begin bad++; $display("FAIL edge_stop_timeout got=%0d want=0", n_to); end
   endtask

   task automatic test_ignore();
      run_trial(0, 10, 50, 60);
      exp_meas = CW'(50);
      total++; if (n_valid !== 1 || valid_meas !== exp_meas) begin bad++; $display("FAIL restart_ignored got=%0d/%0d want=1/%0d", n_valid, valid_meas, exp_meas); end
   endtask

   task automatic test_back_to_back();
      int d[3] = '{5, 99, 20};
      for (int i = 0; i < 3; i++) begin
         run_trial(0, -1, d[i], d[i] + 8);
         exp_meas = CW'(d[i]);
         total++; if (n_valid !== 1 || valid_meas !== exp_meas) begin bad++; $display("FAIL b2b_%0d got=%0d/%0d want=1/%0d", i, n_valid, valid_meas, exp_meas); end
         total++; if (n_to !== 0) begin bad++; $display("FAIL b2b_%0d_timeout got=%0d want=0", i, n_to); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         int d;
         int win;
         d   = int'($urandom_range(0, TO + 10));
         win = ((d > TO) ? d : TO) + 10;
         run_trial(0, -1, d, win);
         if (ref_valid(d)) begin
            exp_meas = CW'(d);
            total++; if (n_valid !== 1 || n_to !== 0 || valid_meas !== exp_meas) begin bad++; $display("FAIL rand_%0d d=%0d got=v%0d t%0d m%0d want=v1 t0 m%0d", i, d, n_valid, n_to, valid_meas, exp_meas); end
         end else begin
            total++; if (n_valid !== 0 || n_to !== 1 || meas !== exp_meas) begin bad++; $display("FAIL rand_%0d d=%0d got=v%0d t%0d m%0d want=v0 t1 m%0d", i, d, n_valid, n_to, meas, exp_meas); end
         end
         total++; if (n_both !== 0) begin bad++; $display("FAIL rand_%0d_exclusive got=%0d want=0", i, n_both); end
         repeat (3) @(negedge clk_pdm);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_minimum();
      test_timeout();
      test_ignore();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
